// File: rtl/fecha_pkg.sv
// Shared definitions for the date loader and the date comparator.
package fecha_pkg;

    // Default field widths and the serial frame length built from them
    localparam int ANCHO_MES_DEF = 4;
    localparam int ANCHO_DIA_DEF = 5;
    localparam int FRAME_DEF     = ANCHO_MES_DEF + ANCHO_DIA_DEF;

    // Width of the idle (no valid bit) counter inside a frame
    localparam int IDLE_W = 8;

    // Frame reception FSM
    typedef enum logic [1:0] {
        REPOSO  = 2'b00,
        RECIBE  = 2'b01,
        ENTREGA = 2'b10
    } estado_t;

    // Comparator result codes, also used by the comparator bench
    typedef enum logic [1:0] {
        INVALIDA = 2'b00,
        VENCIDO  = 2'b01,
        VIGENTE  = 2'b10
    } resultado_t;

    // Bits needed for a counter that must be able to hold the value 'frame'
    function automatic int ancho_contador(input int frame);
        return $clog2(frame + 1);
    endfunction

endpackage

// File: rtl/cargador_fecha_serie_if.sv
// Bus between the label reader / reference port and the date loader.
interface cargador_fecha_serie_if #(
    parameter int ANCHO_MES = 4,
    parameter int ANCHO_DIA = 5
);
    logic                 inicio;
    logic                 dato_serie;
    logic                 dato_valido;
    logic                 ref_carga;
    logic [ANCHO_DIA-1:0] dia_ref_in;
    logic [ANCHO_MES-1:0] mes_ref_in;
    logic [ANCHO_DIA-1:0] dia;
    logic [ANCHO_MES-1:0] mes;
    logic [ANCHO_DIA-1:0] diaRef;
    logic [ANCHO_MES-1:0] mesRef;
    logic                 listo;
    logic                 ocupado;
    logic                 error_to;

    // Reader side: drives the serial frame and the reference load
    modport master (
        output inicio, dato_serie, dato_valido, ref_carga, dia_ref_in, mes_ref_in,
        input  dia, mes, diaRef, mesRef, listo, ocupado, error_to
    );

    // Loader side
    modport slave (
        input  inicio, dato_serie, dato_valido, ref_carga, dia_ref_in, mes_ref_in,
        output dia, mes, diaRef, mesRef, listo, ocupado, error_to
    );
endinterface

// File: rtl/cargador_fecha_serie_temporizador_espera.sv
// Idle-cycle counter used to abort a frame whose bits stop arriving.
module temporizador_espera
    import fecha_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expira_o
);

    // The current idle cycle is the one that brings the count up to TIMEOUT
    localparam logic [IDLE_W-1:0] LIMITE = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] cuenta_q, cuenta_d;

    // Next count: clear wins, otherwise count idle cycles without wrapping
    always_comb begin
        cuenta_d = cuenta_q;
        if (clr_i) begin
            cuenta_d = '0;
        end else if (en_i && (cuenta_q != '1)) begin
            cuenta_d = cuenta_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign expira_o = en_i && (cuenta_q == LIMITE);

endmodule

// File: rtl/cargador_fecha_serie.sv
// Serial expiry-date loader: assembles month/day from a 9-bit MSB-first
// frame and holds the parallel-loaded reference date for the comparator.
module cargador_fecha_serie
    import fecha_pkg::*;
#(
    parameter int ANCHO_MES = ANCHO_MES_DEF,
    parameter int ANCHO_DIA = ANCHO_DIA_DEF,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    cargador_fecha_serie_if.slave  bus
);

    localparam int FRAME  = ANCHO_MES + ANCHO_DIA;
    localparam int BITS_W = ancho_contador(FRAME);
    localparam logic [BITS_W-1:0] ULTIMO = BITS_W'(FRAME - 1);
    localparam logic [BITS_W-1:0] LLENO  = BITS_W'(FRAME);

    estado_t              estado_q, estado_d;
    logic [BITS_W-1:0]    bits_q, bits_d;
    logic [FRAME-1:0]     trama_q, trama_d;
    logic [FRAME-1:0]     trama_completa;
    logic [ANCHO_DIA-1:0] dia_q, dia_d, dia_ref_q, dia_ref_d;
    logic [ANCHO_MES-1:0] mes_q, mes_d, mes_ref_q, mes_ref_d;
    logic                 error_q, error_d;
    logic                 desplaza, completa;
    logic                 espera_en, espera_clr, expira;
    logic                 listo, ocupado;

    // A restart request always beats a data bit arriving in the same cycle
    assign desplaza       = (estado_q == RECIBE) && !bus.inicio && bus.dato_valido;
    assign completa       = desplaza && (bits_q == ULTIMO);
    assign trama_completa = {trama_q[FRAME-2:0], bus.dato_serie};

    // Idle counting only matters inside a frame; any state change or
    // accepted bit/restart starts the idle run again from zero
    assign espera_en  = (estado_q == RECIBE) && !bus.dato_valido;
    assign espera_clr = (estado_d != estado_q) ||
                        ((estado_q == RECIBE) && (bus.inicio || bus.dato_valido));

    temporizador_espera #(
        .TIMEOUT (TIMEOUT)
    ) u_espera (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (espera_clr),
        .en_i     (espera_en),
        .expira_o (expira)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= REPOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // FSM next state; timeout abort raises the error pulse for the next cycle
    always_comb begin
        estado_d = estado_q;
        error_d  = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (bus.inicio) begin
                    estado_d = RECIBE;
                end
            end
            RECIBE: begin
                if (bus.inicio) begin
                    estado_d = RECIBE;
                end else if (expira) begin
                    estado_d = REPOSO;
                    error_d  = 1'b1;
                end else if (completa) begin
                    estado_d = ENTREGA;
                end
            end
            ENTREGA: begin
                estado_d = bus.inicio ? RECIBE : REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        listo   = (estado_q == ENTREGA);
        ocupado = (estado_q == RECIBE);
    end

    // Datapath next values: shift register, bit counter, date fields
    always_comb begin
        bits_d    = bits_q;
        trama_d   = trama_q;
        dia_d     = dia_q;
        mes_d     = mes_q;
        dia_ref_d = dia_ref_q;
        mes_ref_d = mes_ref_q;

        if (bus.inicio || (estado_d != RECIBE)) begin
            bits_d  = '0;
            trama_d = '0;
        end else if (desplaza) begin
            trama_d = trama_completa;
            if (bits_q != LLENO) begin
                bits_d = bits_q + 1'b1;
            end
        end

        // The last bit is taken straight from the input so the fields
        // update on the same edge that samples it
        if (completa) begin
            mes_d = trama_completa[FRAME-1:ANCHO_DIA];
            dia_d = trama_completa[ANCHO_DIA-1:0];
        end

        if (bus.ref_carga) begin
            dia_ref_d = bus.dia_ref_in;
            mes_ref_d = bus.mes_ref_in;
        end
    end

    // Datapath and error-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q    <= '0;
            trama_q   <= '0;
            dia_q     <= '0;
            mes_q     <= '0;
            dia_ref_q <= '0;
            mes_ref_q <= '0;
            error_q   <= 1'b0;
        end else begin
            bits_q    <= bits_d;
            trama_q   <= trama_d;
            dia_q     <= dia_d;
            mes_q     <= mes_d;
            dia_ref_q <= dia_ref_d;
            mes_ref_q <= mes_ref_d;
            error_q   <= error_d;
        end
    end

    assign bus.dia      = dia_q;
    assign bus.mes      = mes_q;
    assign bus.diaRef   = dia_ref_q;
    assign bus.mesRef   = mes_ref_q;
    assign bus.listo    = listo;
    assign bus.ocupado  = ocupado;
    assign bus.error_to = error_q;

endmodule

// File: tb/tb_cargador_fecha_serie.sv
// Bench for the serial date loader: directed scenarios plus random traffic
// against a frame-level reference model.
module tb_cargador_fecha_serie;

    localparam int ANCHO_MES = 4;
    localparam int ANCHO_DIA = 5;
    localparam int TIMEOUT   = 16;
    localparam int FRAME     = ANCHO_MES + ANCHO_DIA;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cargador_fecha_serie_if #(.ANCHO_MES(ANCHO_MES), .ANCHO_DIA(ANCHO_DIA)) bus ();

    cargador_fecha_serie #(
        .ANCHO_MES (ANCHO_MES),
        .ANCHO_DIA (ANCHO_DIA),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a frame in progress is a list of received bits
    bit                   m_en_trama;
    bit                   m_bits[$];
    int                   m_inactivos;
    logic [ANCHO_DIA-1:0] m_dia, m_dref;
    logic [ANCHO_MES-1:0] m_mes, m_mref;
    bit                   m_listo, m_err;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s obs=%0d esp=%0d (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs being applied
    task automatic modelo();
        int v;
        m_listo = 1'b0;
        m_err   = 1'b0;
        if (reset) begin
            m_en_trama  = 1'b0;
            m_bits.delete();
            m_inactivos = 0;
            m_dia = '0; m_mes = '0; m_dref = '0; m_mref = '0;
        end else begin
            if (bus.ref_carga) begin
                m_dref = bus.dia_ref_in;
                m_mref = bus.mes_ref_in;
            end
            if (bus.inicio) begin
                m_en_trama  = 1'b1;
                m_bits.delete();
                m_inactivos = 0;
            end else if (m_en_trama) begin
                if (bus.dato_valido) begin
                    m_bits.push_back(bus.dato_serie);
                    m_inactivos = 0;
                    if (m_bits.size() == FRAME) begin
                        v = 0;
                        foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
                        m_mes      = ANCHO_MES'(v / (1 << ANCHO_DIA));
                        m_dia      = ANCHO_DIA'(v % (1 << ANCHO_DIA));
                        m_listo    = 1'b1;
                        m_en_trama = 1'b0;
                    end
                end else begin
                    m_inactivos++;
                    if (m_inactivos == TIMEOUT) begin
                        m_en_trama = 1'b0;
                        m_err      = 1'b1;
                    end
                end
            end
        end
    endtask

    // One clock cycle: drive on the falling edge, update the model on the
    // rising edge, compare shortly after it
    task automatic ciclo(input bit rst, input bit ini, input bit dv, input bit ds,
                         input bit rc, input logic [ANCHO_DIA-1:0] dr,
                         input logic [ANCHO_MES-1:0] mr);
        @(negedge clk);
        reset           = rst;
        bus.inicio      = ini;
        bus.dato_valido = dv;
        bus.dato_serie  = ds;
        bus.ref_carga   = rc;
        bus.dia_ref_in  = dr;
        bus.mes_ref_in  = mr;
        @(posedge clk);
        modelo();
        #1;
        comprobar("dia",      32'(bus.dia),      32'(m_dia));
        comprobar("mes",      32'(bus.mes),      32'(m_mes));
        comprobar("diaRef",   32'(bus.diaRef),   32'(m_dref));
        comprobar("mesRef",   32'(bus.mesRef),   32'(m_mref));
        comprobar("listo",    32'(bus.listo),    32'(m_listo));
        comprobar("ocupado",  32'(bus.ocupado),  32'(m_en_trama));
        comprobar("error_to", 32'(bus.error_to), 32'(m_err));
        comprobar("exclusion", 32'(bus.listo & bus.error_to), 32'd0);
    endtask

    task automatic inactivo();
        ciclo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic arrancar();
        ciclo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Send n bits of 'valor' starting at bit index 'alto', MSB first,
    // with 'huecos' idle cycles before each bit
    task automatic enviar_bits(input int valor, input int alto, input int n, input int huecos);
        for (int i = alto; i > alto - n; i--) begin
            repeat (huecos) inactivo();
            ciclo(1'b0, 1'b0, 1'b1, valor[i], 1'b0, '0, '0);
        end
    endtask

    task automatic enviar_trama(input int valor, input int huecos);
        arrancar();
        enviar_bits(valor, FRAME - 1, FRAME, huecos);
    endtask

    initial begin
        reset = 1'b1;
        bus.inicio = 1'b0; bus.dato_valido = 1'b0; bus.dato_serie = 1'b0;
        bus.ref_carga = 1'b0; bus.dia_ref_in = '0; bus.mes_ref_in = '0;

        // Reset state and quiet hold
        ciclo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        ciclo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) inactivo();
        comprobar("reset_mes", 32'(bus.mes), 32'd0);

        // Frame 0010_01110 with back-to-back bits
        arrancar();
        comprobar("ocupado_trama", 32'(bus.ocupado), 32'd1);
        enviar_bits(9'b0010_01110, FRAME - 1, FRAME, 0);
        comprobar("t2_mes",   32'(bus.mes),   32'd2);
        comprobar("t2_dia",   32'(bus.dia),   32'd14);
        comprobar("t2_listo", 32'(bus.listo), 32'd1);
        inactivo();
        comprobar("t2_listo_fin", 32'(bus.listo), 32'd0);

        // Same frame with idle gaps, then a frame abandoned after 4 bits
        enviar_trama(9'b0010_01110, 3);
        comprobar("t3_listo", 32'(bus.listo), 32'd1);
        inactivo();
        arrancar();
        enviar_bits(9'b1111_00000, FRAME - 1, 4, 0);
        repeat (TIMEOUT - 1) inactivo();
        comprobar("t3_sin_error", 32'(bus.error_to), 32'd0);
        inactivo();
        comprobar("t3_error",   32'(bus.error_to), 32'd1);
        comprobar("t3_ocupado", 32'(bus.ocupado),  32'd0);
        comprobar("t3_dia",     32'(bus.dia),      32'd14);
        inactivo();
        comprobar("t3_error_fin", 32'(bus.error_to), 32'd0);

        // Restart mid-frame, then 1100_11111
        arrancar();
        enviar_bits(9'b0101_01010, FRAME - 1, 5, 0);
        enviar_trama(9'b1100_11111, 0);
        comprobar("t4_mes", 32'(bus.mes), 32'd12);
        comprobar("t4_dia", 32'(bus.dia), 32'd31);
        inactivo();

        // Reference load during reception
        arrancar();
        enviar_bits(9'b0011_00111, FRAME - 1, 3, 0);
        ciclo(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 4'd3);
        comprobar("t5_mesRef", 32'(bus.mesRef), 32'd3);
        comprobar("t5_diaRef", 32'(bus.diaRef), 32'd1);
        enviar_bits(9'b0011_00111, FRAME - 5, FRAME - 4, 0);
        comprobar("t5_mes", 32'(bus.mes), 32'd3);
        comprobar("t5_dia", 32'(bus.dia), 32'd7);
        inactivo();

        // Reset mid-frame, then a frame followed by a back-to-back one
        arrancar();
        enviar_bits(9'b1010_10101, FRAME - 1, 6, 0);
        ciclo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        comprobar("t6_ocupado", 32'(bus.ocupado), 32'd0);
        enviar_trama(9'b0001_00001, 0);
        comprobar("t6_mes", 32'(bus.mes), 32'd1);
        comprobar("t6_dia", 32'(bus.dia), 32'd1);
        enviar_trama(9'b1001_10011, 0);
        comprobar("t6_b2b_mes", 32'(bus.mes), 32'd9);
        comprobar("t6_b2b_dia", 32'(bus.dia), 32'd19);
        inactivo();

        // Random traffic, alternating dense and sparse data phases
        for (int c = 0; c < 1600; c++) begin
            int pdv;
            pdv = (((c / 200) % 2) == 0) ? 70 : 6;
            ciclo($urandom_range(0, 399) == 0,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < pdv,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 5,
                  ANCHO_DIA'($urandom),
                  ANCHO_MES'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cargador_fecha_serie.md
Name: cargador_fecha_serie

Overview:
Upstream stage of the date comparator. It receives the product expiry date as a 9-bit serial frame (month then day) from the label reader and registers the reference date from a parallel load port. It presents stable dia/mes/diaRef/mesRef buses to the comparator, plus a one-cycle listo strobe on every completed frame. It does no range checking; the comparator owns date validation.

Parameters:
ANCHO_MES, 4, month field width in bits
ANCHO_DIA, 5, day field width in bits
TIMEOUT, 16, consecutive idle cycles (dato_valido=0) inside a frame that abort it; legal range 2..255

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
inicio  input  1  frame start request
dato_serie  input  1  serial data bit, MSB-first
dato_valido  input  1  dato_serie is valid this cycle
ref_carga  input  1  load reference date this cycle
dia_ref_in  input  ANCHO_DIA  reference day to load
mes_ref_in  input  ANCHO_MES  reference month to load
dia  output  ANCHO_DIA  day of last complete frame
mes  output  ANCHO_MES  month of last complete frame
diaRef  output  ANCHO_DIA  registered reference day
mesRef  output  ANCHO_MES  registered reference month
listo  output  1  one-cycle pulse: dia/mes just updated
ocupado  output  1  frame reception in progress
error_to  output  1  one-cycle pulse: frame aborted by timeout

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset, all outputs are 0, state is REPOSO, and the bit and idle counters are 0. Asserting reset mid-frame discards the partial frame and produces no listo and no error_to.
- Frame format: FRAME = ANCHO_MES+ANCHO_DIA = 9 bits, month MSB first, then day MSB first. The shift register shifts left and enters new bits at the LSB.
- FSM states: REPOSO, RECIBE, ENTREGA.
- REPOSO: ocupado=0. If inicio=1, go to RECIBE and clear both counters. A dato_valido in the same cycle as inicio is ignored; the first data bit is sampled on a later cycle.
- RECIBE: ocupado=1.
  - dato_valido=1: shift in dato_serie, increment the bit counter, clear the idle counter.
  - dato_valido=0: increment the idle counter.
  - On the edge that samples the 9th valid bit: load mes/dia from the assembled frame on that same edge, then go to ENTREGA.
  - When the idle counter reaches TIMEOUT: go to REPOSO, pulse error_to=1 for the next cycle, and leave dia/mes unchanged.
  - inicio=1 while in RECIBE: restart the frame. Counters clear, the partial frame is discarded, and no error is raised. inicio takes priority over a same-cycle data bit.
- ENTREGA: lasts exactly one cycle. listo=1 and ocupado=0.
  - inicio=1 here is handled exactly as in REPOSO, so back-to-back frames have no dead cycle beyond ENTREGA.
  - Otherwise go to REPOSO.
- Latency: listo and the new dia/mes are visible in the cycle after the edge that sampled the last bit. dia/mes hold their value until the next completed frame.
- listo and error_to are never high together.
- Reference date: ref_carga=1 loads diaRef/mesRef on the next edge, in any FSM state and independently of framing. It does not affect listo.
- After reset, dia=0 and mes=0, which the comparator classifies as invalid (00). This is the intended power-up indication.
- Width rules:
  - Bit counter: $clog2(FRAME+1) bits, saturating (no wrap).
  - Idle counter: 8 bits, compared for equality with TIMEOUT, and cleared on every state change.

Decomposition:
- Shared package fecha_pkg holds:
  - ANCHO_DIA/ANCHO_MES defaults and FRAME width;
  - FSM state encoding (REPOSO=2'b00, RECIBE=2'b01, ENTREGA=2'b10);
  - comparator result codes (INVALIDA=2'b00, VENCIDO=2'b01, VIGENTE=2'b10), shared with the comparator bench.
- One sub-module: temporizador_espera, the idle counter with clear/enable/expire, parameterised by TIMEOUT. The shift register and FSM stay in the top module.

Test Plan:
1. Reset -> dia=0, mes=0, diaRef=0, mesRef=0, listo=0, ocupado=0, error_to=0 one cycle after reset; all hold with no stimulus.
2. inicio, then 9 consecutive valid bits 0010_01110 -> ocupado=1 during the bits; next cycle mes=2, dia=14, listo=1 for exactly one cycle; then ocupado=0.
3. Same frame with 3 idle cycles between bits (TIMEOUT=16) -> identical result, no error_to. Then a new frame: 4 bits followed by 16 idle cycles -> error_to one-cycle pulse, ocupado=0, dia/mes still 14/2, no listo.
4. inicio, 5 bits, inicio again, then frame 1100_11111 -> single listo; mes=12, dia=31.
5. ref_carga with mes_ref_in=3, dia_ref_in=1 during RECIBE -> mesRef=3, diaRef=1 next cycle; the in-progress frame completes unaffected.
6. reset after 6 bits -> no listo/error_to, ocupado=0. The following full frame 0001_00001 -> mes=1, dia=1, listo pulse. Back-to-back frame started with inicio during ENTREGA is also accepted.
